// File: rtl/wb_arbiter_pkg.sv
// Shared field widths, source numbering and helpers for the writeback arbiter.
package wb_arbiter_pkg;

  localparam int ROBID_W  = 8;
  localparam int PREG_W   = 6;
  localparam int ECAUSE_W = 5;

  localparam int SRC_CSR = 0;
  localparam int SRC_ALU = 1;
  localparam int SRC_BR  = 2;
  localparam int SRC_LSQ = 3;

  // Next round-robin position after idx in a ring of n slots.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// N-wide round-robin arbiter: one-hot grant scanning upward from a rotating
// pointer that moves just past the winner whenever a grant is taken.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] rr_ptr;

  always_comb begin
    int idx;
    logic [IW-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      sel = IW'(idx);
      if (!grant_any && req[sel]) begin
        grant_any  = 1'b1;
        grant_idx  = sel;
        grant[sel] = 1'b1;
      end
    end
  end

  // The pointer only moves when the grant is actually consumed (held on flush).
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance && grant_any) begin
      rr_ptr <= IW'(wrap_inc(int'(grant_idx), N));
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one skid entry per functional unit, round-robin drained
// onto a single registered writeback bus; ROB flush discards everything in flight.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int RW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          src_valid,
  output logic [NSRC-1:0]          src_ready,
  input  logic [NSRC-1:0]          src_error,
  input  logic [ECAUSE_W*NSRC-1:0] src_ecause,
  input  logic [ROBID_W*NSRC-1:0]  src_robid,
  input  logic [PREG_W*NSRC-1:0]   src_rd,
  input  logic [RW*NSRC-1:0]       src_result,
  input  logic                     rob_flush,
  output logic                     wb_valid,
  output logic                     wb_error,
  output logic [ECAUSE_W-1:0]      wb_ecause,
  output logic [ROBID_W-1:0]       wb_robid,
  output logic [PREG_W-1:0]        wb_rd,
  output logic [RW-1:0]            wb_result
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]     buf_v;
  logic [NSRC-1:0]     buf_error;
  logic [ECAUSE_W-1:0] buf_ecause [NSRC];
  logic [ROBID_W-1:0]  buf_robid  [NSRC];
  logic [PREG_W-1:0]   buf_rd     [NSRC];
  logic [RW-1:0]       buf_result [NSRC];

  logic [NSRC-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [NSRC-1:0] take;

  rr_arbiter #(.N(NSRC)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (buf_v),
    .advance   (~rob_flush),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready depends only on buffer occupancy and this cycle's grant, never on src_valid.
  assign src_ready = ~buf_v | grant;
  assign take      = src_valid & src_ready & {NSRC{~rob_flush}};

  always_ff @(posedge clk) begin
    if (rst || rob_flush) begin
      buf_v <= '0;
    end else begin
      buf_v <= take | (buf_v & ~grant);
    end
  end

  // Payload storage needs no reset; it is only observed behind buf_v.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (take[i]) begin
        buf_error[i]  <= src_error[i];
        buf_ecause[i] <= src_ecause[ECAUSE_W*i +: ECAUSE_W];
        buf_robid[i]  <= src_robid[ROBID_W*i +: ROBID_W];
        buf_rd[i]     <= src_rd[PREG_W*i +: PREG_W];
        buf_result[i] <= src_result[RW*i +: RW];
      end
    end
  end

  // Payload holds across idle cycles so only wb_valid toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_error  <= 1'b0;
      wb_ecause <= '0;
      wb_robid  <= '0;
      wb_rd     <= '0;
      wb_result <= '0;
    end else if (rob_flush) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= grant_any;
      if (grant_any) begin
        wb_error  <= buf_error[grant_idx];
        wb_ecause <= buf_ecause[grant_idx];
        wb_robid  <= buf_robid[grant_idx];
        wb_rd     <= buf_rd[grant_idx];
        wb_result <= buf_result[grant_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expected values.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         rob_flush;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [3:0]   src_error;
  logic [19:0]  src_ecause;
  logic [31:0]  src_robid;
  logic [23:0]  src_rd;
  logic [127:0] src_result;
  logic         wb_valid;
  logic         wb_error;
  logic [4:0]   wb_ecause;
  logic [7:0]   wb_robid;
  logic [5:0]   wb_rd;
  logic [31:0]  wb_result;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.NSRC(4), .RW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_error  (src_error),
    .src_ecause (src_ecause),
    .src_robid  (src_robid),
    .src_rd     (src_rd),
    .src_result (src_result),
    .rob_flush  (rob_flush),
    .wb_valid   (wb_valid),
    .wb_error   (wb_error),
    .wb_ecause  (wb_ecause),
    .wb_robid   (wb_robid),
    .wb_rd      (wb_rd),
    .wb_result  (wb_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic err, input logic [4:0] ec,
                               input logic [7:0] robid, input logic [5:0] rd, input logic [31:0] res);
    src_valid[i]          = v;
    src_error[i]          = err;
    src_ecause[5*i +: 5]  = ec;
    src_robid[8*i +: 8]   = robid;
    src_rd[6*i +: 6]      = rd;
    src_result[32*i +: 32] = res;
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    rob_flush = 1'b0;
    src_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rob_flush  = 1'b0;
    src_valid  = '0;
    src_error  = '0;
    src_ecause = '0;
    src_robid  = '0;
    src_rd     = '0;
    src_result = '0;
    doReset();

    // Reset state
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_ready", 64'(src_ready), 64'hF);
    checkOutput("rst_wb_robid", 64'(wb_robid), 64'd0);
    checkOutput("rst_wb_result", 64'(wb_result), 64'd0);
    checkOutput("rst_wb_error", 64'(wb_error), 64'd0);

    // Single CSR transfer, 2-edge latency, one-cycle pulse
    applyStimulus(0, 1'b1, 1'b0, 5'd0, 8'h12, 6'd5, 32'hDEADBEEF);
    step();
    src_valid = '0;
    checkOutput("csr_no_bypass", 64'(wb_valid), 64'd0);
    step();
    checkOutput("csr_valid", 64'(wb_valid), 64'd1);
    checkOutput("csr_robid", 64'(wb_robid), 64'h12);
    checkOutput("csr_rd", 64'(wb_rd), 64'd5);
    checkOutput("csr_result", 64'(wb_result), 64'hDEADBEEF);
    step();
    checkOutput("csr_pulse_end", 64'(wb_valid), 64'd0);
    checkOutput("csr_payload_hold", 64'(wb_robid), 64'h12);

    // rr_ptr now 1: sources 0 and 1 together drain as 1 then 0
    applyStimulus(0, 1'b1, 1'b0, 5'd0, 8'h30, 6'd1, 32'h30);
    applyStimulus(1, 1'b1, 1'b0, 5'd0, 8'h31, 6'd2, 32'h31);
    step();
    src_valid = '0;
    step();
    checkOutput("ptr1_first", 64'(wb_robid), 64'h31);
    step();
    checkOutput("ptr1_second", 64'(wb_robid), 64'h30);
    checkOutput("ptr1_second_v", 64'(wb_valid), 64'd1);

    // All four sources at once from rr_ptr = 0
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(i, 1'b1, 1'b0, 5'd0, 8'(8'h20 + i), 6'(i), 32'(32'h100 + i));
    step();
    src_valid = '0;
    checkOutput("all4_ready_c1", 64'(src_ready), 64'b0001);
    step();
    checkOutput("all4_robid0", 64'(wb_robid), 64'h20);
    checkOutput("all4_ready_c2", 64'(src_ready), 64'b0011);
    step();
    checkOutput("all4_robid1", 64'(wb_robid), 64'h21);
    checkOutput("all4_ready_c3", 64'(src_ready), 64'b0111);
    step();
    checkOutput("all4_robid2", 64'(wb_robid), 64'h22);
    checkOutput("all4_result2", 64'(wb_result), 64'h102);
    step();
    checkOutput("all4_robid3", 64'(wb_robid), 64'h23);
    checkOutput("all4_valid3", 64'(wb_valid), 64'd1);
    step();
    checkOutput("all4_drained", 64'(wb_valid), 64'd0);

    // Streaming from ALU alone, robids 0..9 back-to-back
    for (int k = 0; k < 12; k++) begin
      if (k < 10) applyStimulus(1, 1'b1, 1'b0, 5'd0, 8'(k), 6'd7, 32'(k));
      else        src_valid = '0;
      checkOutput($sformatf("stream_ready_%0d", k), 64'(src_ready[1]), 64'd1);
      step();
      if (k >= 1 && k <= 10) begin
        checkOutput($sformatf("stream_valid_%0d", k), 64'(wb_valid), 64'd1);
        checkOutput($sformatf("stream_robid_%0d", k), 64'(wb_robid), 64'(k - 1));
      end else begin
        checkOutput($sformatf("stream_idle_%0d", k), 64'(wb_valid), 64'd0);
      end
    end

    // Contention between CSR and branch: strict alternation
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 5'd0, 8'h80, 6'd0, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 5'd0, 8'h82, 6'd2, 32'h2);
    for (int k = 0; k < 7; k++) begin
      step();
      if (k >= 1) begin
        checkOutput($sformatf("fair_valid_%0d", k), 64'(wb_valid), 64'd1);
        checkOutput($sformatf("fair_robid_%0d", k), 64'(wb_robid), (k % 2 == 1) ? 64'h80 : 64'h82);
      end
    end
    src_valid = '0;

    // Flush with all buffers full; flush-cycle transfers dropped, rr_ptr held
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(i, 1'b1, 1'b0, 5'd0, 8'(8'h50 + i), 6'd0, 32'h0);
    step();
    for (int i = 0; i < 4; i++)
      applyStimulus(i, 1'b1, 1'b0, 5'd0, 8'(8'h60 + i), 6'd0, 32'h0);
    rob_flush = 1'b1;
    step();
    rob_flush = 1'b0;
    src_valid = '0;
    checkOutput("flush_wb_valid", 64'(wb_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("flush_quiet_%0d", k), 64'(wb_valid), 64'd0);
    end
    applyStimulus(0, 1'b1, 1'b0, 5'd0, 8'h70, 6'd0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 5'd0, 8'h71, 6'd0, 32'h0);
    step();
    src_valid = '0;
    step();
    checkOutput("flush_ptr_first", 64'(wb_robid), 64'h70);
    step();
    checkOutput("flush_ptr_second", 64'(wb_robid), 64'h71);

    // Exception pass-through, then reset mid-stream
    applyStimulus(0, 1'b1, 1'b1, 5'd2, 8'h40, 6'd9, 32'hBAD);
    step();
    applyStimulus(0, 1'b1, 1'b0, 5'd0, 8'h41, 6'd9, 32'h0);
    step();
    checkOutput("exc_valid", 64'(wb_valid), 64'd1);
    checkOutput("exc_error", 64'(wb_error), 64'd1);
    checkOutput("exc_ecause", 64'(wb_ecause), 64'd2);
    checkOutput("exc_robid", 64'(wb_robid), 64'h40);
    rst = 1'b1;
    step();
    checkOutput("midrst_valid", 64'(wb_valid), 64'd0);
    checkOutput("midrst_robid", 64'(wb_robid), 64'd0);
    checkOutput("midrst_error", 64'(wb_error), 64'd0);
    checkOutput("midrst_ready", 64'(src_ready), 64'hF);
    rst = 1'b0;
    src_valid = '0;
    step();
    checkOutput("midrst_quiet", 64'(wb_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter directly downstream of the CSR unit and the other functional units (ALU, branch, LSQ).
- Each source hands over one completed op per cycle with robid, destination tag, result and exception info.
- The block buffers one entry per source and round-robin selects one per cycle onto the single registered writeback bus consumed by the ROB and the physical register file.
- Results in flight are discarded on ROB flush.

Parameters:
- NSRC, 4, number of source units; source 0 = CSR, source 1 = ALU, source 2 = branch, source 3 = LSQ.
- RW, 32, result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- src_valid  in  NSRC  per-source result valid.
- src_ready  out  NSRC  per-source accept. A transfer occurs when valid and ready are both high.
- src_error  in  NSRC  per-source exception flag.
- src_ecause  in  5*NSRC  exception cause, packed; source i occupies bits [5i+4:5i].
- src_robid  in  8*NSRC  ROB index, packed.
- src_rd  in  6*NSRC  physical destination tag, packed.
- src_result  in  RW*NSRC  result, packed.
- rob_flush  in  1  pipeline flush.
- wb_valid  out  1  writeback bus valid.
- wb_error  out  1  exception flag.
- wb_ecause  out  5  exception cause.
- wb_robid  out  8  ROB index.
- wb_rd  out  6  physical destination tag.
- wb_result  out  RW  result.

Behaviour:
- Reset:
  - All buffer valid bits = 0; rr_ptr = 0.
  - wb_valid = 0, wb_error = 0, wb_ecause = 0, wb_robid = 0, wb_rd = 0, wb_result = 0.
  - src_ready = all ones from the first cycle after reset.
- Per-source buffer: one entry holding {error, ecause, robid, rd, result} plus a valid bit.
- Ready rule: src_ready[i] = !buf_v[i] || grant[i]. This is combinational from buffer state and grant only, never from src_valid (no combinational path from valid to ready).
- Grant: combinational over buf_v.
  - Pick the first set index at or after rr_ptr, scanning upward with wrap modulo NSRC.
  - At most one grant per cycle; no grant if all buffers are empty.
- rr_ptr update: on any grant, rr_ptr <= (grant_idx + 1) mod NSRC. Otherwise it holds.
- Output register:
  - wb_valid <= grant_any.
  - On a grant, the wb_* payload loads from the granted buffer.
  - Without a grant, the payload holds its old value and only wb_valid drops.
- Latency:
  - A source transfer at edge t makes the entry visible in its buffer after t.
  - If granted in cycle t+1, the result appears on wb_* after edge t+1.
  - Minimum latency is 2 edges; there is no input-to-output bypass.
- Simultaneous grant and new transfer on the same source: the buffer is overwritten with the new entry and stays valid. Full throughput is one per cycle per source when uncontended.
- No backpressure from the writeback bus: the consumer always accepts.
- Flush (rob_flush = 1 in cycle t):
  - At edge t: all buf_v <= 0 and wb_valid <= 0.
  - Source transfers in cycle t are dropped, even though ready was high.
  - rr_ptr is unchanged.
- Starvation bound: a full buffer is granted within NSRC cycles.
- Reset has priority over flush; flush has priority over grant and load.
- Error entries arbitrate identically to normal results.

Decomposition:
- Shared package holds:
  - Field widths: ROBID_W = 8, PREG_W = 6, ECAUSE_W = 5.
  - Source index constants: SRC_CSR, SRC_ALU, SRC_BR, SRC_LSQ.
- One natural sub-module: rr_arbiter (NSRC-wide round-robin grant with pointer register; inputs req and advance, outputs one-hot grant and index).
- Payload muxing and buffers stay in wb_arbiter.

Test Plan:
- Reset then single CSR transfer:
  - Stimulus: cycle 1 sets src_valid = 0001 with robid 0x12, rd 5, result 0xDEADBEEF.
  - Required: wb_valid = 1 with those values after edge 2, for exactly one cycle. rr_ptr = 1 afterwards.
- All four sources valid in the same cycle, rr_ptr = 0:
  - Required: wb_robid order is source 0, 1, 2, 3 on consecutive cycles.
  - src_ready returns to 1 per source the cycle after its grant.
- Continuous streaming from source 1 alone, robids 0..9:
  - Required: src_ready[1] stays high throughout.
  - wb_robid runs 0..9 in order on back-to-back cycles, with no gaps after the initial 2-cycle latency.
- Contention fairness:
  - Stimulus: sources 0 and 2 hold valid continuously.
  - Required: grants alternate 0, 2, 0, 2; neither source waits more than 2 cycles.
- Flush with all buffers full:
  - Stimulus: assert rob_flush one cycle while src_valid = 1111.
  - Required: wb_valid = 0 the following cycle. No pre-flush or flush-cycle robid ever appears on wb_*.
- Exception pass-through:
  - Stimulus: source 0 sends error = 1, ecause = 2, robid 0x40.
  - Required: wb_error = 1, wb_ecause = 2, wb_robid = 0x40. Reset asserted mid-stream clears wb_valid next cycle.
